cond_logic: RTL
===============

# cond_logic

Conditional-execution unit directly downstream of the ALU flag generator. Holds the architectural NZCV flag register, evaluates the 4-bit instruction condition field against the stored flags, and gates the decoder's write strobes (PC, register file, memory, flags). Sits between the ALU flags outputs / main decoder and the datapath write enables.

## Interface

- No parameters (flag width fixed at 4: N, Z, C, V).

- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  stage enable; low = stall (all state holds).
- ALUFlags  in  4  {N,Z,C,V} from the ALU flag generator, current cycle.
- Cond  in  4  instruction condition field [31:28].
- FlagW  in  2  [1] = write N,Z; [0] = write C,V (from decoder).
- PCS  in  1  decoder: instruction writes PC.
- RegW  in  1  decoder: instruction writes register file.
- MemW  in  1  decoder: instruction writes memory.
- NoWrite  in  1  decoder: compare-type op, suppress RegWrite.
- PCSrc  out  1  gated PC write select.
- RegWrite  out  1  gated register-file write.
- MemWrite  out  1  gated memory write.
- CondEx  out  1  combinational condition result, current cycle.
- CondExR  out  1  CondEx registered (one cycle delayed), for multi-cycle control.
- Flags  out  4  stored {N,Z,C,V}.

## Operation

- Condition evaluated on stored Flags (pre-update value), never on ALUFlags.
- Codes: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as 1.
- FlagWrite[1:0] = FlagW & {2{CondEx}}.
- On clock edge with en=1: FlagWrite[1] loads Flags[3:2] <= ALUFlags[3:2]; FlagWrite[0] loads Flags[1:0] <= ALUFlags[1:0]; halves independent.
- PCSrc = PCS & CondEx; RegWrite = RegW & CondEx & ~NoWrite; MemWrite = MemW & CondEx.
- CondExR <= CondEx when en=1.
- en=0: Flags and CondExR hold; combinational outputs still track inputs, but no flag update occurs.

## Timing

- Reset (async, immediate): Flags = 4'b0000, CondExR = 0. Combinational outputs then follow inputs with Flags=0 (e.g. EQ evaluates false, NE true).
- CondEx, PCSrc, RegWrite, MemWrite: zero-cycle (combinational) latency.
- Flag update visible on Flags and in condition evaluation from the cycle after the writing instruction.
- Back-to-back: CMP in cycle n, BEQ in cycle n+1 sees the CMP result.
- Same-cycle write and evaluate: instruction with Cond and FlagW evaluates on old flags, then writes new ones.
- Reset deasserted mid-stream: first edge after release behaves as a normal cycle from Flags=0.
- rst asserted while en=1 and FlagW active: reset wins, Flags=0.

## Structure

- Shared package cond_pkg: cond_t enum for the 16 condition codes, flag bit-index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One combinational sub-module cond_check (Cond, Flags -> CondEx); the top holds both flag-half registers, CondExR and the gating.

## Test plan

- Reset: assert rst with ALUFlags=4'hF, FlagW=2'b11 -> Flags=0, CondExR=0; Cond=0001 gives CondEx=1, Cond=0000 gives 0.
- Split write: Cond=1110, FlagW=2'b10, ALUFlags=4'b0111 -> next cycle Flags=4'b0100; then FlagW=2'b01, ALUFlags=4'b1011 -> Flags=4'b0111.
- Condition suppression: Flags=4'b0000, Cond=0000 (EQ), RegW=MemW=PCS=1, FlagW=2'b11, ALUFlags=4'hF -> RegWrite=MemWrite=PCSrc=0, Flags stay 0.
- Signed compare codes: Flags N=1,V=0,Z=0 -> LT=1, GE=0, GT=0, LE=1; Flags N=1,V=1,Z=0 -> GE=1, GT=1.
- NoWrite: Cond=1110, RegW=1, NoWrite=1, FlagW=2'b11 -> RegWrite=0, flags updated next cycle.
- Stall: en=0, FlagW=2'b11, ALUFlags=4'hA -> Flags and CondExR unchanged; en=1 next cycle -> Flags=4'hA.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: condition codes and
// NZCV bit positions within the flag register.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational evaluation of a 4-bit condition field against the
// stored NZCV flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;

  always_comb begin
    n  = Flags[FLAG_N];
    z  = Flags[FLAG_Z];
    c  = Flags[FLAG_C];
    v  = Flags[FLAG_V];
    ge = (n == v);

    CondEx = 1'b1;
    case (cond_t'(Cond))
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      // 1111 has no "never" meaning here; it executes like AL.
      COND_AL, COND_NV: CondEx = 1'b1;
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds NZCV, evaluates the condition on the stored
// (pre-update) flags and gates the decoder's write strobes with the result.
module cond_logic
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] ALUFlags,
  input  logic [3:0] Cond,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic       CondExR,
  output logic [3:0] Flags
);

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       cond_ex_r_q;
  logic [1:0] flag_write;

  assign Flags   = {nz_q, cv_q};
  assign CondExR = cond_ex_r_q;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  // A failed condition suppresses every architectural side effect, flags included.
  always_comb begin
    flag_write = FlagW & {2{CondEx}};
    nz_d       = flag_write[1] ? ALUFlags[FLAG_N:FLAG_Z] : nz_q;
    cv_d       = flag_write[0] ? ALUFlags[FLAG_C:FLAG_V] : cv_q;
    PCSrc      = PCS & CondEx;
    RegWrite   = RegW & CondEx & ~NoWrite;
    MemWrite   = MemW & CondEx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nz_q        <= 2'b00;
      cv_q        <= 2'b00;
      cond_ex_r_q <= 1'b0;
    end else if (en) begin
      nz_q        <= nz_d;
      cv_q        <= cv_d;
      cond_ex_r_q <= CondEx;
    end
  end

endmodule
